// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Input-side front end for the calculator. Raw push-button pins come in
// asynchronously to clk. Each bit goes through a two-flop synchroniser, then a
// per-bit debouncer, then a registered edge detector. A small two-state FSM
// turns each clean press into a single held command with a valid/ready
// handshake, so the operation FSM downstream sees exactly one command per
// physical press. It never sees a bounce glitch or a repeat from a held level.
//
// Parameters
//   N_BTN            number of buttons (1..8)
//   DEBOUNCE_CYCLES  consecutive cycles of disagreement needed to accept a
//                    change of the debounced level
//   CNT_W            debounce counter width; must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset; clears every flop
//   btn_raw      raw button pins, asynchronous to clk
//   btn_level    debounced button levels
//   btn_press    one-cycle pulse, cycle after a debounced rising edge
//   btn_release  one-cycle pulse, cycle after a debounced falling edge
//   cmd_valid    a command is pending; held until accepted
//   cmd_code     zero-extended index of the pressed button; stable while valid
//   cmd_ready    consumer accepts the command when cmd_valid & cmd_ready
//   overrun      sticky flag: a press was dropped while a command was pending
//                or lost to a simultaneous lower-index press
// ---------------------------------------------------------------------------
module button_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             cmd_valid,
   output logic [2:0]       cmd_code,
   input  logic             cmd_ready,
   output logic             overrun
);

   // Terminal count of the debounce counter. The change is accepted on the
   // DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;

   logic [N_BTN-1:0] level_q;
   logic [N_BTN-1:0] level_d;
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [CNT_W-1:0] cnt_d [N_BTN];

   logic [N_BTN-1:0] levelDly_q;
   logic [N_BTN-1:0] press_q;
   logic [N_BTN-1:0] release_q;

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       code_q;
   logic [2:0]       code_d;
   logic             overrun_q;
   logic             overrun_d;

   logic [2:0]       lowIdx;
   logic             multiPress;

   // ------------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------------
   // The raw pins are asynchronous to clk. Two flop stages bring them into
   // the clock domain before any logic looks at them. Only the second stage
   // feeds the debouncer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------
   // Debounce next-state
   // ------------------------------------------------------------------
   // Each bit is handled on its own. The counter runs only while the
   // synchronised input disagrees with the accepted level. A single cycle of
   // agreement, such as a bounce back to the old value, throws the count
   // away. Reaching the terminal count flips the level and rearms the
   // counter from zero.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               level_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Debounce registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Edge detection
   // ------------------------------------------------------------------
   // The edge pulses compare the registered level against a one-cycle-delayed
   // copy of itself. As a result, press and release come out one cycle after
   // btn_level changes and last exactly one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         levelDly_q <= '0;
         press_q    <= '0;
         release_q  <= '0;
      end else begin
         levelDly_q <= level_q;
         press_q    <= level_q & ~levelDly_q;
         release_q  <= ~level_q & levelDly_q;
      end
   end

   // ------------------------------------------------------------------
   // Press arbitration helpers
   // ------------------------------------------------------------------
   // The lowest-index press wins. The loop scans from the top down, so the
   // last assignment belongs to the lowest set bit. Clearing the lowest set
   // bit (x & (x-1)) leaves something only when two or more presses landed
   // in the same cycle.
   always_comb begin
      lowIdx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (press_q[i]) begin
            lowIdx = 3'(i);
         end
      end
      multiPress = |(press_q & (press_q - N_BTN'(1)));
   end

   // ------------------------------------------------------------------
   // Command FSM next-state
   // ------------------------------------------------------------------
   // IDLE captures the winning press and moves to PEND. PEND holds the code
   // until the consumer takes it. Presses that cannot be delivered are not
   // queued. They only set the sticky overrun flag, and this includes a
   // press that arrives in the same cycle as the accept.
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      overrun_d = overrun_q;
      case (state_q)
         IDLE: begin
            if (|press_q) begin
               code_d  = lowIdx;
               state_d = PEND;
               if (multiPress) begin
                  overrun_d = 1'b1;
               end
            end
         end
         PEND: begin
            if (|press_q) begin
               overrun_d = 1'b1;
            end
            if (cmd_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Command FSM registers
   // ------------------------------------------------------------------
   // Reset discards any pending command outright. Because the edge detector
   // is also cleared, no stale pulse can re-create the command. A button
   // still held after reset is debounced again from level 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         code_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         overrun_q <= overrun_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // All outputs come straight from flops. cmd_valid is simply "in PEND".
   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign cmd_valid   = (state_q == PEND);
   assign cmd_code    = code_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Drives button_conditioner with directed scenarios followed by a long
// randomised run. Every cycle, all outputs are compared against a
// behavioural model. The model tracks the raw pins through a two-sample
// delay, then counts consecutive samples that disagree with the accepted
// level. It arbitrates presses by population count and lowest set bit.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int NB = 5;
   localparam int DB = 4;
   localparam int CW = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          cmd_valid;
   logic [2:0]    cmd_code;
   logic          cmd_ready;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [NB-1:0] mSample1;
   logic [NB-1:0] mSample2;
   logic [NB-1:0] mLevel;
   logic [NB-1:0] mLevelPrev;
   logic [NB-1:0] mPress;
   logic [NB-1:0] mRelease;
   int            mRun [NB];
   bit            mValid;
   int            mCode;
   bit            mOverrun;

   button_conditioner #(
      .N_BTN(NB),
      .DEBOUNCE_CYCLES(DB),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .cmd_valid(cmd_valid),
      .cmd_code(cmd_code),
      .cmd_ready(cmd_ready),
      .overrun(overrun)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Clears all model state, matching the effect of reset.
   task automatic modelReset();
      mSample1   = '0;
      mSample2   = '0;
      mLevel     = '0;
      mLevelPrev = '0;
      mPress     = '0;
      mRelease   = '0;
      for (int i = 0; i < NB; i++) mRun[i] = 0;
      mValid   = 1'b0;
      mCode    = 0;
      mOverrun = 1'b0;
   endtask

   // Advances the model by one clock edge. It uses the inputs present at
   // that edge.
   task automatic modelEdge(input logic [NB-1:0] raw, input bit ready);
      logic [NB-1:0] newLevel;
      bit            found;
      newLevel = mLevel;
      // A level is accepted after DB consecutive disagreeing samples.
      for (int i = 0; i < NB; i++) begin
         if (mSample2[i] != mLevel[i]) begin
            if (mRun[i] + 1 == DB) begin
               newLevel[i] = mSample2[i];
               mRun[i] = 0;
            end else begin
               mRun[i] = mRun[i] + 1;
            end
         end else begin
            mRun[i] = 0;
         end
      end
      // Command handling is driven by last cycle's press pulses.
      if (!mValid) begin
         if (mPress != 0) begin
            found = 1'b0;
            for (int i = 0; i < NB; i++) begin
               if (mPress[i] && !found) begin
                  mCode = i;
                  found = 1'b1;
               end
            end
            mValid = 1'b1;
            if ($countones(mPress) > 1) mOverrun = 1'b1;
         end
      end else begin
         if (mPress != 0) mOverrun = 1'b1;
         if (ready) mValid = 1'b0;
      end
      mPress     = mLevel & ~mLevelPrev;
      mRelease   = ~mLevel & mLevelPrev;
      mLevelPrev = mLevel;
      mLevel     = newLevel;
      mSample2   = mSample1;
      mSample1   = raw;
   endtask

   task automatic compareAll();
      checkOutput("btn_level", 32'(btn_level), 32'(mLevel));
      checkOutput("btn_press", 32'(btn_press), 32'(mPress));
      checkOutput("btn_release", 32'(btn_release), 32'(mRelease));
      checkOutput("cmd_valid", 32'(cmd_valid), 32'(mValid));
      checkOutput("cmd_code", 32'(cmd_code), 32'(mCode));
      checkOutput("overrun", 32'(overrun), 32'(mOverrun));
   endtask

   // One clock cycle. Inputs change on the falling edge. Outputs are
   // compared 1 ns after the rising edge and, when reset is asserted, also
   // right after it goes high.
   task automatic applyStimulus(input logic [NB-1:0] raw, input bit ready,
                                input bit rst);
      @(negedge clk);
      btn_raw   = raw;
      cmd_ready = ready;
      reset     = rst;
      if (rst) begin
         modelReset();
         #1;
         compareAll();
      end
      @(posedge clk);
      if (!rst) modelEdge(raw, ready);
      #1;
      compareAll();
   endtask

   initial begin
      int            pressCnt;
      int            releaseCnt;
      int            validCnt;
      logic [NB-1:0] curRaw;
      bit            rdy;
      bit            rst;

      btn_raw   = '0;
      cmd_ready = 1'b0;
      reset     = 1'b1;
      modelReset();

      // Reset held: outputs stay zero while the raw pins toggle.
      for (int c = 0; c < 3; c++) applyStimulus('0, 1'b0, 1'b1);
      for (int c = 0; c < 8; c++) begin
         applyStimulus(NB'($urandom), 1'b0, 1'b1);
         checkOutput("rst_hold",
                     32'({btn_level, btn_press, btn_release, cmd_valid, cmd_code, overrun}),
                     32'(0));
      end
      for (int c = 0; c < 3; c++) applyStimulus('0, 1'b1, 1'b0);

      // Clean press of bit1. The level rises at edge 6, followed by one
      // press pulse and one command.
      pressCnt = 0;
      validCnt = 0;
      for (int e = 1; e <= 12; e++) begin
         applyStimulus(5'b00010, 1'b1, 1'b0);
         if (e == 5) checkOutput("s2_level_e5", 32'(btn_level[1]), 32'(0));
         if (e == 6) checkOutput("s2_level_e6", 32'(btn_level[1]), 32'(1));
         pressCnt += int'(btn_press[1]);
         if (cmd_valid) begin
            validCnt++;
            checkOutput("s2_code", 32'(cmd_code), 32'(1));
         end
      end
      checkOutput("s2_press_count", 32'(pressCnt), 32'(1));
      checkOutput("s2_valid_count", 32'(validCnt), 32'(1));

      // Release bit1. This gives a release pulse and no command.
      releaseCnt = 0;
      validCnt   = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus('0, 1'b1, 1'b0);
         releaseCnt += int'(btn_release[1]);
         validCnt   += int'(cmd_valid);
      end
      checkOutput("s2_release_count", 32'(releaseCnt), 32'(1));
      checkOutput("s2_release_nocmd", 32'(validCnt), 32'(0));

      // Bouncing bit3 followed by a steady press: exactly one press, and the
      // level rises on the 6th edge after the last bounce.
      applyStimulus(5'b01000, 1'b1, 1'b0);
      applyStimulus(5'b00000, 1'b1, 1'b0);
      applyStimulus(5'b01000, 1'b1, 1'b0);
      applyStimulus(5'b00000, 1'b1, 1'b0);
      pressCnt = 0;
      for (int e = 1; e <= 12; e++) begin
         applyStimulus(5'b01000, 1'b1, 1'b0);
         if (e == 5) checkOutput("s3_level_e5", 32'(btn_level[3]), 32'(0));
         if (e == 6) checkOutput("s3_level_e6", 32'(btn_level[3]), 32'(1));
         pressCnt += int'(btn_press[3]);
      end
      checkOutput("s3_press_count", 32'(pressCnt), 32'(1));
      for (int c = 0; c < 10; c++) applyStimulus('0, 1'b1, 1'b0);

      // Stalled consumer. Code 2 is held. A later press of bit4 sets
      // overrun and is dropped.
      for (int c = 0; c < 30; c++) begin
         applyStimulus(5'b00100, 1'b0, 1'b0);
         if (c >= 10) begin
            checkOutput("s4_hold_valid", 32'(cmd_valid), 32'(1));
            checkOutput("s4_hold_code", 32'(cmd_code), 32'(2));
         end
      end
      for (int c = 0; c < 10; c++) applyStimulus(5'b10100, 1'b0, 1'b0);
      checkOutput("s4_overrun", 32'(overrun), 32'(1));
      checkOutput("s4_code_kept", 32'(cmd_code), 32'(2));
      applyStimulus(5'b10100, 1'b1, 1'b0);
      checkOutput("s4_accept_drop", 32'(cmd_valid), 32'(0));
      validCnt = 0;
      for (int c = 0; c < 15; c++) begin
         applyStimulus(5'b10100, 1'b1, 1'b0);
         validCnt += int'(cmd_valid);
      end
      checkOutput("s4_no_bit4_cmd", 32'(validCnt), 32'(0));
      checkOutput("s4_overrun_sticky", 32'(overrun), 32'(1));
      for (int c = 0; c < 12; c++) applyStimulus('0, 1'b1, 1'b0);

      // Two buttons stepped together: one command, code 2, overrun set.
      applyStimulus('0, 1'b1, 1'b1);
      applyStimulus('0, 1'b1, 1'b0);
      validCnt = 0;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(5'b10100, 1'b1, 1'b0);
         if (cmd_valid) begin
            validCnt++;
            checkOutput("s5_code", 32'(cmd_code), 32'(2));
         end
      end
      checkOutput("s5_valid_count", 32'(validCnt), 32'(1));
      checkOutput("s5_overrun", 32'(overrun), 32'(1));

      // Release bit2: a release pulse and no command. Then press bit2 again,
      // reset while the command is pending, and keep the buttons held.
      releaseCnt = 0;
      validCnt   = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(5'b10000, 1'b1, 1'b0);
         releaseCnt += int'(btn_release[2]);
         validCnt   += int'(cmd_valid);
      end
      checkOutput("s6_release_count", 32'(releaseCnt), 32'(1));
      checkOutput("s6_release_nocmd", 32'(validCnt), 32'(0));
      for (int c = 0; c < 12; c++) applyStimulus(5'b10100, 1'b0, 1'b0);
      checkOutput("s6_pend_valid", 32'(cmd_valid), 32'(1));
      applyStimulus(5'b10100, 1'b0, 1'b1);
      checkOutput("s6_reset_valid", 32'(cmd_valid), 32'(0));
      validCnt = 0;
      for (int e = 1; e <= 12; e++) begin
         applyStimulus(5'b10100, 1'b1, 1'b0);
         if (e == 1) checkOutput("s6_no_stale", 32'(cmd_valid), 32'(0));
         if (e == 5) checkOutput("s6_level_e5", 32'(btn_level), 32'(0));
         if (e == 6) checkOutput("s6_level_e6", 32'(btn_level), 32'(5'b10100));
         validCnt += int'(cmd_valid);
      end
      checkOutput("s6_fresh_cmd", 32'(validCnt), 32'(1));

      // Randomised run: flicker-prone buttons, an erratic consumer and rare
      // resets.
      curRaw = 5'b10100;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 15) == 0) curRaw[b] = ~curRaw[b];
         end
         rdy = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 599) == 0);
         applyStimulus(curRaw, rdy, rst);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
